step_pulse_shaper: RTL

- Sits directly downstream of the segment step generator, between it and the external stepper driver pins (p1..p8 header).
- Turns abstract step requests (one per step, with direction) into driver-legal STEP/DIR waveforms:
  - DIR setup time before each step after a direction change;
  - minimum STEP high width and minimum STEP low width.
- Buffers up to a bounded number of same-direction steps so that short request bursts are never lost.
- Backpressures the generator through a valid/ready handshake.

---
 rtl/step_pulse_shaper.sv | 136 +++++++++++++
 1 files changed

// File: rtl/step_pulse_shaper.sv
// Shapes step requests into driver-legal STEP/DIR waveforms with DIR setup, min high/low widths and a pending-step buffer.
// Optional build macro STEP_PULSE_INVERT_EN makes step_out active-low (idle/reset level 1); dir_out is unaffected.
module step_pulse_shaper #(
    parameter int SetupCycles  = 20,
    parameter int HighCycles   = 24,
    parameter int LowCycles    = 24,
    parameter int PendingWidth = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_valid,
    input  logic                    step_dir,
    output logic                    step_ready,
    output logic                    step_out,
    output logic                    dir_out,
    output logic [PendingWidth-1:0] pending,
    output logic                    busy
);

    localparam int MaxHl     = (HighCycles > LowCycles) ? HighCycles : LowCycles;
    localparam int MaxCycles = (SetupCycles > MaxHl) ? SetupCycles : MaxHl;
    localparam int TimerW    = ($clog2(MaxCycles) < 1) ? 1 : $clog2(MaxCycles);

    localparam logic [TimerW-1:0]       SetupLoad = TimerW'(SetupCycles - 1);
    localparam logic [TimerW-1:0]       HighLoad  = TimerW'(HighCycles - 1);
    localparam logic [TimerW-1:0]       LowLoad   = TimerW'(LowCycles - 1);
    localparam logic [PendingWidth-1:0] PendMax   = '1;

`ifdef STEP_PULSE_INVERT_EN
    localparam logic StepIdle = 1'b1;
`else
    localparam logic StepIdle = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIR_SETUP  = 2'd1,
        PULSE_HIGH = 2'd2,
        PULSE_LOW  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic [PendingWidth-1:0] pending_q, pending_d;
    logic                    queued_dir_q, queued_dir_d;
    logic                    dir_out_q, dir_out_d;
    logic                    step_out_q, step_out_d;
    logic                    xfer;
    logic                    pulse_start;

    // Ready never looks at step_valid, so the generator can't form a loop through us.
    assign step_ready = (pending_q != PendMax) &&
                        ((pending_q == '0) || (step_dir == queued_dir_q));
    assign xfer       = step_valid && step_ready;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        dir_out_d    = dir_out_q;
        queued_dir_d = xfer ? step_dir : queued_dir_q;
        pulse_start  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    if (queued_dir_q != dir_out_q) begin
                        dir_out_d = queued_dir_q;
                        timer_d   = SetupLoad;
                        state_d   = DIR_SETUP;
                    end else begin
                        timer_d     = HighLoad;
                        state_d     = PULSE_HIGH;
                        pulse_start = 1'b1;
                    end
                end
            end
            DIR_SETUP: begin
                if (timer_q == '0) begin
                    timer_d     = HighLoad;
                    state_d     = PULSE_HIGH;
                    pulse_start = 1'b1;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            PULSE_HIGH: begin
                if (timer_q == '0) begin
                    timer_d = LowLoad;
                    state_d = PULSE_LOW;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            PULSE_LOW: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case ({xfer, pulse_start})
            2'b10:   pending_d = pending_q + PendingWidth'(1);
            2'b01:   pending_d = pending_q - PendingWidth'(1);
            default: pending_d = pending_q;
        endcase

        step_out_d = (state_d == PULSE_HIGH) ^ StepIdle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pending_q    <= '0;
            queued_dir_q <= 1'b0;
            dir_out_q    <= 1'b0;
            step_out_q   <= StepIdle;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            queued_dir_q <= queued_dir_d;
            dir_out_q    <= dir_out_d;
            step_out_q   <= step_out_d;
        end
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign pending  = pending_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);

endmodule
